memory_arbiter: RTL

Single-port memory arbiter between the CPU's instruction-fetch and data-access paths and the shared RAM. Consumes the registered data strobes (`dmemREN`/`dmemWEN`) produced by the request unit plus the instruction-fetch strobe, and grants one access at a time with data priority. Returns one-cycle `ihit`/`dhit` pulses that the request unit uses to clear its strobes and advance the PC. Includes a watchdog that aborts any RAM access that never completes.

---
 rtl/memory_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for the fetch and data paths, with data priority and an access watchdog.
// One RAM access at a time; hits are single-cycle pulses decoded from state registers.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight, picks data over fetch
// BUSY  | RAM strobe asserted, waiting for ramready or watchdog expiry
// RESP  | one-cycle hit to the granted requester, strobes low
module memory_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        merr
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic GNT_INSTR = 1'b0;
    localparam logic GNT_DATA  = 1'b1;
    localparam logic [31:0] BAD_LOAD = 32'hBAD1BAD1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, next_state;
    logic          gnt;
    logic          wr;
    logic [CW-1:0] cnt;
    logic          tmo;

    assign tmo = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (dREN || dWEN || iREN) next_state = BUSY;
            BUSY:    if (ramready || tmo)      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ramREN = 1'b0;
        ramWEN = 1'b0;
        ihit   = 1'b0;
        dhit   = 1'b0;
        case (state)
            BUSY: begin
                ramWEN = wr;
                ramREN = !wr;
            end
            RESP: begin
                ihit = (gnt == GNT_INSTR);
                dhit = (gnt == GNT_DATA);
            end
            default: ;
        endcase
    end

    // Address/data latched once at grant so requester changes during BUSY cannot leak to the RAM.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iload    <= '0;
            dload    <= '0;
            ramaddr  <= '0;
            ramstore <= '0;
            gnt      <= GNT_INSTR;
            wr       <= 1'b0;
            cnt      <= '0;
            merr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dREN || dWEN) begin
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        gnt      <= GNT_DATA;
                        wr       <= dWEN;
                        cnt      <= '0;
                    end else if (iREN) begin
                        ramaddr <= iaddr;
                        gnt     <= GNT_INSTR;
                        wr      <= 1'b0;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    if (ramready) begin
                        if (!wr) begin
                            if (gnt == GNT_DATA) dload <= ramload;
                            else                 iload <= ramload;
                        end
                    end else if (tmo) begin
                        if (!wr) begin
                            if (gnt == GNT_DATA) dload <= BAD_LOAD;
                            else                 iload <= BAD_LOAD;
                        end
                        merr <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
